// File: rtl/vram_port_arbiter.sv
// Frame-RAM arbiter: VGA fetch (highest priority), clear engine, then the update port.
// Define VRAM_ARB_STATS_EN to enable the stall_cnt statistics counter.
`timescale 1ns/1ps
module vram_port_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 15,
   parameter int H_RES = 160,
   parameter int V_RES = 120,
   parameter int RD_LAT = 1,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vga_req,
   input  logic [9:0]        vga_x,
   input  logic [9:0]        vga_y,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_q,
   output logic [15:0]       stall_cnt
);
   localparam int DEPTH = H_RES * V_RES;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;
   state_t state, state_nxt;

   logic [ADDR_W-1:0] clr_addr;
   logic [ADDR_W-1:0] vga_lin;
   logic              vga_in_range, req_in_range;
   logic              slot_rd, slot_we, slot_vga, slot_zero, clear_take, clear_last;
   logic [ADDR_W-1:0] slot_addr;
   logic [DATA_W-1:0] slot_wdata;
   logic              s0_rd, s0_we, s0_vga, s0_zero;
   logic [ADDR_W-1:0] s0_addr;
   logic [DATA_W-1:0] s0_wdata;
   logic [RD_LAT:0]   tag_rd, tag_vga, tag_zero;

   assign vga_lin      = ADDR_W'(32'(vga_y) * 32'(H_RES) + 32'(vga_x));
   assign vga_in_range = (32'(vga_x) < 32'(H_RES)) && (32'(vga_y) < 32'(V_RES));
   assign req_in_range = 32'(req_addr) < 32'(DEPTH);
   assign clear_last   = clear_take && (clr_addr == LAST_ADDR);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (clear_start) state_nxt = CLEAR;
         CLEAR: if (clear_last)  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      clear_busy = (state == CLEAR);
      req_ready  = (state == IDLE) && !vga_req;
   end

   // One slot per cycle; out-of-range reads still occupy a slot so their latency stays fixed.
   always_comb begin
      slot_rd    = 1'b0;
      slot_we    = 1'b0;
      slot_vga   = 1'b0;
      slot_zero  = 1'b0;
      clear_take = 1'b0;
      slot_addr  = clr_addr;
      slot_wdata = CLEAR_VAL;
      if (vga_req) begin
         slot_rd   = 1'b1;
         slot_vga  = 1'b1;
         slot_zero = !vga_in_range;
         slot_addr = vga_lin;
      end else if (state == CLEAR) begin
         slot_we    = 1'b1;
         clear_take = 1'b1;
      end else if (req_valid) begin
         slot_addr  = req_addr;
         slot_wdata = req_wdata;
         if (req_we) begin
            slot_we = req_in_range;
         end else begin
            slot_rd   = 1'b1;
            slot_zero = !req_in_range;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clr_addr   <= '0;
         clear_done <= 1'b0;
      end else begin
         clear_done <= clear_last;
         if (state == IDLE && clear_start) clr_addr <= '0;
         else if (clear_take)              clr_addr <= clr_addr + ADDR_W'(1);
      end
   end

   // Grant stage, then the registered RAM port one cycle later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_rd     <= 1'b0;
         s0_we     <= 1'b0;
         s0_vga    <= 1'b0;
         s0_zero   <= 1'b0;
         s0_addr   <= '0;
         s0_wdata  <= '0;
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_wdata <= '0;
      end else begin
         s0_rd    <= slot_rd;
         s0_we    <= slot_we;
         s0_vga   <= slot_vga;
         s0_zero  <= slot_zero;
         s0_addr  <= slot_addr;
         s0_wdata <= slot_wdata;
         ram_we   <= s0_we;
         if (s0_we || (s0_rd && !s0_zero)) ram_addr  <= s0_addr;
         if (s0_we)                         ram_wdata <= s0_wdata;
      end
   end

   // Read tags follow each read to the cycle its ram_q word is ready to capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_rd     <= '0;
         tag_vga    <= '0;
         tag_zero   <= '0;
         vga_rvalid <= 1'b0;
         vga_rdata  <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         tag_rd     <= {tag_rd[RD_LAT-1:0], s0_rd};
         tag_vga    <= {tag_vga[RD_LAT-1:0], s0_vga};
         tag_zero   <= {tag_zero[RD_LAT-1:0], s0_zero};
         vga_rvalid <= tag_rd[RD_LAT] && tag_vga[RD_LAT];
         rsp_valid  <= tag_rd[RD_LAT] && !tag_vga[RD_LAT];
         if (tag_rd[RD_LAT] && tag_vga[RD_LAT])
            vga_rdata <= tag_zero[RD_LAT] ? '0 : ram_q;
         if (tag_rd[RD_LAT] && !tag_vga[RD_LAT])
            rsp_rdata <= tag_zero[RD_LAT] ? '0 : ram_q;
      end
   end

`ifdef VRAM_ARB_STATS_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                               stall_q <= '0;
      else if (req_valid && !req_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter: random and directed traffic against a frame-level model.
// Honours VRAM_ARB_STATS_EN for the expected stall_cnt.
`timescale 1ns/1ps
module tb_vram_port_arbiter;
   localparam int H_RES  = 160;
   localparam int V_RES  = 120;
   localparam int DEPTH  = H_RES * V_RES;
   localparam int RD_LAT = 1;
   localparam logic [31:0] CLEAR_VAL = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        vga_req;
   logic [9:0]  vga_x, vga_y;
   logic        vga_rvalid;
   logic [31:0] vga_rdata;
   logic        req_valid, req_ready, req_we;
   logic [14:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        clear_start, clear_busy, clear_done;
   logic [14:0] ram_addr;
   logic        ram_we;
   logic [31:0] ram_wdata, ram_q;
   logic [15:0] stall_cnt;

   vram_port_arbiter dut (
      .clk(clk), .rst(rst),
      .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y),
      .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int a);
      return (32'(a) * 32'h9E3779B1) ^ 32'hC0FFEE11;
   endfunction

   // RAM macro stand-in: read-first, RD_LAT cycles from address to ram_q.
   logic [31:0] mem [32768];
   bit          written [32768];
   logic [31:0] qpipe [RD_LAT];
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr]     <= ram_wdata;
         written[ram_addr] <= 1'b1;
      end
      qpipe[0] <= written[ram_addr] ? mem[ram_addr] : init_word(int'(ram_addr));
      for (int k = 1; k < RD_LAT; k++) qpipe[k] <= qpipe[k-1];
   end
   assign ram_q = qpipe[RD_LAT-1];

   typedef struct {logic [31:0] data; int due;} rd_exp_t;
   typedef struct {int addr; logic [31:0] data; int due;} wr_exp_t;
   typedef struct {bit v; int addr; logic [31:0] old;} hist_t;

   rd_exp_t vga_q[$];
   rd_exp_t rsp_q[$];
   wr_exp_t wr_q[$];
   int      done_q[$];
   hist_t   hist_q[$];

   logic [31:0] ref_mem [int];
   bit clearing = 0;
   int clear_pos = 0;
   int stall_model = 0;
   bit accepted;
   int done_seen = 0;
   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] ref_read(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic reportUnexpected(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got an output pulse, expected none (cycle %0d)", name, cyc);
   endtask

   // One cycle of stimulus; the model decides the grant and queues what the DUT must produce.
   task automatic applyStimulus(input bit v_req, input int vx, input int vy, input bit r_valid,
                                input bit r_we, input int r_addr, input logic [31:0] r_wdata,
                                input bit c_start);
      bit exp_ready, was_clearing;
      int exp_stall;
      hist_t h;
      @(negedge clk);
      vga_req = v_req; vga_x = 10'(vx); vga_y = 10'(vy);
      req_valid = r_valid; req_we = r_we; req_addr = 15'(r_addr); req_wdata = r_wdata;
      clear_start = c_start;
      #1;
      was_clearing = clearing;
      exp_ready = !clearing && !v_req;
`ifdef VRAM_ARB_STATS_EN
      exp_stall = stall_model;
`else
      exp_stall = 0;
`endif
      checkOutput("clear_busy", 32'(clear_busy), 32'(clearing));
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      accepted = r_valid && exp_ready;
      h = '{v: 1'b0, addr: 0, old: 32'h0};
      if (v_req) begin
         if (vx < H_RES && vy < V_RES) vga_q.push_back('{ref_read(vy * H_RES + vx), cyc + 3 + RD_LAT});
         else                          vga_q.push_back('{32'h0, cyc + 3 + RD_LAT});
      end else if (clearing) begin
         h = '{v: 1'b1, addr: clear_pos, old: ref_read(clear_pos)};
         wr_q.push_back('{clear_pos, CLEAR_VAL, cyc + 2});
         ref_mem[clear_pos] = CLEAR_VAL;
         clear_pos++;
         if (clear_pos == DEPTH) begin
            clearing = 0;
            done_q.push_back(cyc + 1);
         end
      end else if (r_valid) begin
         if (r_we) begin
            if (r_addr < DEPTH) begin
               h = '{v: 1'b1, addr: r_addr, old: ref_read(r_addr)};
               wr_q.push_back('{r_addr, r_wdata, cyc + 2});
               ref_mem[r_addr] = r_wdata;
            end
         end else begin
            rsp_q.push_back('{(r_addr < DEPTH) ? ref_read(r_addr) : 32'h0, cyc + 3 + RD_LAT});
         end
      end
      if (!was_clearing && c_start) begin
         clearing = 1;
         clear_pos = 0;
      end
      if (r_valid && !exp_ready && stall_model < 65535) stall_model++;
      hist_q.push_back(h);
      if (hist_q.size() > 2) void'(hist_q.pop_front());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 0);
   endtask

   // Reset mid-stream: the two most recent grants never reach the RAM, so the model forgets them.
   task automatic doReset();
      hist_t h;
      @(negedge clk);
      vga_req = 0; req_valid = 0; clear_start = 0;
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_clear_busy", 32'(clear_busy), 32'h0);
      checkOutput("rst_ram_we", 32'(ram_we), 32'h0);
      checkOutput("rst_clear_done", 32'(clear_done), 32'h0);
      while (hist_q.size() > 0) begin
         h = hist_q.pop_back();
         if (h.v) ref_mem[h.addr] = h.old;
      end
      vga_q.delete(); rsp_q.delete(); wr_q.delete(); done_q.delete();
      clearing = 0; clear_pos = 0; stall_model = 0;
      repeat (3) begin
         @(negedge clk); #1;
         checkOutput("rst_hold_ram_we", 32'(ram_we), 32'h0);
         checkOutput("rst_hold_clear_busy", 32'(clear_busy), 32'h0);
      end
      @(negedge clk); #2 rst = 1'b1;
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a pulse or a RAM write.
   always @(negedge clk) begin
      rd_exp_t r;
      wr_exp_t w;
      int d;
      if (vga_rvalid) begin
         if (vga_q.size() == 0) reportUnexpected("vga_rvalid");
         else begin
            r = vga_q.pop_front();
            checkOutput("vga_rdata", vga_rdata, r.data);
            checkOutput("vga_latency", 32'(cyc), 32'(r.due));
         end
      end
      if (rsp_valid) begin
         if (rsp_q.size() == 0) reportUnexpected("rsp_valid");
         else begin
            r = rsp_q.pop_front();
            checkOutput("rsp_rdata", rsp_rdata, r.data);
            checkOutput("rsp_latency", 32'(cyc), 32'(r.due));
         end
      end
      if (ram_we) begin
         if (wr_q.size() == 0) reportUnexpected("ram_we");
         else begin
            w = wr_q.pop_front();
            checkOutput("ram_addr_wr", 32'(ram_addr), 32'(w.addr));
            checkOutput("ram_wdata", ram_wdata, w.data);
            checkOutput("ram_wr_time", 32'(cyc), 32'(w.due));
         end
      end
      if (clear_done) begin
         done_seen++;
         if (done_q.size() == 0) reportUnexpected("clear_done");
         else begin
            d = done_q.pop_front();
            checkOutput("clear_done_time", 32'(cyc), 32'(d));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit pv, pwe, vr;
      int paddr, vx, vy, guard, bad;
      logic [31:0] pdata;

      rst = 1'b0;
      vga_req = 0; vga_x = '0; vga_y = '0;
      req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; clear_start = 0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_vga_rvalid", 32'(vga_rvalid), 32'h0);
      checkOutput("reset_vga_rdata", vga_rdata, 32'h0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("reset_clear_busy", 32'(clear_busy), 32'h0);
      checkOutput("reset_clear_done", 32'(clear_done), 32'h0);
      checkOutput("reset_ram_addr", 32'(ram_addr), 32'h0);
      checkOutput("reset_ram_we", 32'(ram_we), 32'h0);
      checkOutput("reset_ram_wdata", ram_wdata, 32'h0);
      checkOutput("reset_stall_cnt", 32'(stall_cnt), 32'h0);
      checkOutput("reset_req_ready", 32'(req_ready), 32'h1);
      @(negedge clk); #2 rst = 1'b1;

      $display("[TB] VGA read x=3 y=2");
      applyStimulus(1, 3, 2, 0, 0, 0, 32'h0, 0);
      idle(2);
      checkOutput("vga_ram_addr", 32'(ram_addr), 32'd323);
      checkOutput("vga_ram_we", 32'(ram_we), 32'h0);
      idle(4);

      $display("[TB] VGA/update conflict");
      applyStimulus(1, 1, 1, 1, 1, 5, 32'hDEADBEEF, 0);
      applyStimulus(0, 0, 0, 1, 1, 5, 32'hDEADBEEF, 0);
      idle(4);

      $display("[TB] write-then-read and boundaries");
      applyStimulus(0, 0, 0, 1, 1, 7, 32'h12345678, 0);
      applyStimulus(0, 0, 0, 1, 0, 7, 32'h0, 0);
      applyStimulus(1, 160, 0, 0, 0, 0, 32'h0, 0);
      applyStimulus(1, 0, 120, 0, 0, 0, 32'h0, 0);
      applyStimulus(1, 159, 119, 0, 0, 0, 32'h0, 0);
      applyStimulus(0, 0, 0, 1, 1, DEPTH, 32'hAAAA5555, 0);
      applyStimulus(0, 0, 0, 1, 0, DEPTH, 32'h0, 0);
      applyStimulus(0, 0, 0, 1, 0, DEPTH - 1, 32'h0, 0);
      idle(6);

      $display("[TB] random traffic");
      pv = 0; pwe = 0; paddr = 0; pdata = 0;
      for (int i = 0; i < 2000; i++) begin
         vr = ($urandom % 2) == 1;
         vx = $urandom_range(0, 170);
         vy = $urandom_range(0, 125);
         if (!pv && ($urandom % 2) == 1) begin
            pv = 1;
            pwe = ($urandom % 2) == 1;
            if (($urandom % 10) == 0)     paddr = $urandom_range(DEPTH, 32767);
            else if (($urandom % 2) == 0) paddr = $urandom_range(0, 15);
            else                          paddr = $urandom_range(0, DEPTH - 1);
            pdata = $urandom;
         end
         applyStimulus(vr, vx, vy, pv, pwe, paddr, pdata, 0);
         if (accepted) pv = 0;
      end
      if (pv) applyStimulus(0, 0, 0, 1, pwe, paddr, pdata, 0);
      idle(8);

      $display("[TB] full clear with VGA every 4th cycle");
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 1);
      guard = 0;
      while (clearing && guard < 30000) begin
         applyStimulus((guard % 4) == 3, $urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1),
                       1, 0, 9, 32'h0, (guard % 1000) == 500);
         guard++;
      end
      if (clearing) reportUnexpected("clear_timeout");
      pv = 1; guard = 0;
      while (pv && guard < 10) begin
         applyStimulus(0, 0, 0, 1, 0, 9, 32'h0, 0);
         if (accepted) pv = 0;
         guard++;
      end
      idle(8);
      checkOutput("clear_done_count", 32'(done_seen), 32'd1);
      bad = 0;
      for (int a = 0; a < DEPTH; a++)
         if (!written[a] || mem[a] != CLEAR_VAL) bad++;
      checkOutput("clear_all_words", 32'(bad), 32'd0);

      $display("[TB] reset mid-clear");
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 1);
      guard = 0;
      while (clearing && clear_pos < 100 && guard < 500) begin
         idle(1);
         guard++;
      end
      doReset();
      idle(10);
      checkOutput("no_done_after_reset", 32'(done_seen), 32'd1);
      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom % 2) == 1, $urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1),
                       ($urandom % 2) == 1, ($urandom % 2) == 1, $urandom_range(0, 127), $urandom, 0);
      end
      idle(8);
      checkOutput("vga_q_drained", 32'(vga_q.size()), 32'd0);
      checkOutput("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
      checkOutput("wr_q_drained", 32'(wr_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares the single-port frame RAM between the VGA pixel-fetch path and the button/switch-driven update logic.
- VGA reads have strict priority. The update port uses a valid/ready handshake. A built-in clear engine fills the RAM after a board-level clear request.
- Sits between the VGA timing block, the RAM update logic and the RAM macro; runs on the pixel clock.

Parameters:
- DATA_W, 32, RAM word width.
- ADDR_W, 15, RAM address width.
- H_RES, 160, words per line; caller pre-scales vga_x to this range.
- V_RES, 120, lines; DEPTH = H_RES*V_RES = 19200, must be < 2**ADDR_W.
- RD_LAT, 1, RAM read latency in cycles (1 or 2).
- CLEAR_VAL, 0, word written by the clear engine.

Ports:
- clk  in  1  pixel clock, single clock domain.
- rst  in  1  asynchronous, active-low reset.
- vga_req  in  1  VGA fetch strobe, one per needed word.
- vga_x  in  10  fetch column.
- vga_y  in  10  fetch row.
- vga_rvalid  out  1  one-cycle pulse: vga_rdata updated.
- vga_rdata  out  DATA_W  fetched word; holds between pulses.
- req_valid  in  1  update-port request.
- req_ready  out  1  update-port accept.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  update address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse: update-port read data valid.
- rsp_rdata  out  DATA_W  update-port read data; holds.
- clear_start  in  1  pulse: start full-RAM clear.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse at clear completion.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_q  in  DATA_W  RAM read data, RD_LAT cycles after ram_addr.
- stall_cnt  out  16  optional statistics (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM = IDLE, clear address counter = 0, read-tag pipeline flushed. Reset mid-clear aborts the clear; no clear_done is issued.
- FSM states:
  - IDLE: update port serviced.
  - CLEAR: clear engine owns the write slot.
  - IDLE->CLEAR on clear_start; clear counter loads 0.
  - CLEAR->IDLE on the cycle the word at DEPTH-1 is issued; clear_done pulses that same cycle.
  - clear_start while in CLEAR is ignored.
- Slot arbitration, evaluated every cycle, priority order:
  - vga_req.
  - In CLEAR: clear write.
  - In IDLE: update-port request.
- req_ready = IDLE && !vga_req (combinational). A transfer happens when req_valid && req_ready. Requesters hold their request until it is accepted.
- Issue timing: a request accepted at edge t drives ram_addr/ram_we/ram_wdata from edge t+1. ram_we is high only for a write slot and is 0 in a cycle with no slot.
- VGA address = vga_y*H_RES + vga_x, computed at full width, then truncated to ADDR_W.
- Read tags travel RD_LAT+1 stages. ram_q is captured into vga_rdata or rsp_rdata at edge t+2+RD_LAT, and the matching valid pulses that cycle. Total read latency is RD_LAT+2 and is fixed; back-to-back reads are supported every cycle.
- VGA out of range (vga_x >= H_RES or vga_y >= V_RES): no RAM access (ram_we=0). vga_rdata = 0 and vga_rvalid pulses at the same latency as a normal read.
- Update port, req_addr >= DEPTH: the request is accepted. A write is dropped. A read returns 0 with rsp_valid at normal latency.
- Clear stalled by vga_req: the counter holds and the word is issued in the next free cycle. clear_busy = (state == CLEAR).
- A write and a later read of the same address, both from the update port, return the new data. Ordering is preserved because issue is in-order.

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- Defined: stall_cnt counts cycles with req_valid && !req_ready, saturates at 16'hFFFF, and clears only on reset.
- Undefined: stall_cnt is tied to 0 and no counter logic is present.

Test Plan:
- Reset then VGA read: vga_req with x=3, y=2, RD_LAT=1 -> ram_addr=323 one cycle after acceptance; vga_rvalid and vga_rdata=ram_q three cycles after acceptance; ram_we=0 throughout.
- Conflict: vga_req and req_valid (write addr 5, data 32'hDEADBEEF) in the same cycle -> req_ready=0; write issued the cycle after vga_req drops; with the stats macro defined, stall_cnt=1.
- Clear: clear_start -> clear_busy high; all 19200 addresses written with 0, each exactly once. With vga_req asserted every 4th cycle, clear_done pulses after 19200 write slots; req_ready stays 0 until clear_done.
- Boundaries: vga_x=160 -> no RAM access, vga_rdata=0, valid at normal latency. Update-port write to addr 19200 -> dropped. Update-port read of addr 19200 -> rsp_rdata=0.
- Reset mid-clear: rst low at word 100 -> clear_busy=0 immediately; clear_done never pulses; ram_we=0.
- Write-then-read: update-port write addr 7 = 32'h12345678, next-cycle read addr 7 -> rsp_rdata=32'h12345678.
